// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_e;

endpackage

// File: rtl/nibble_serial_adder_add4_slice.sv
// Purely combinational 4-bit ripple slice used once per RUN cycle.
module add4_slice
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign sum  = full[NIBBLE_W-1:0];
    assign cout = full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial A+B+cin, one nibble per cycle, LSB nibble first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                  out_cout
`ifdef NSA_OVERFLOW_EN
   ,output logic                  out_ovf
`endif
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = $clog2(NIBBLES) + 1;

    nsa_state_e          state_q;
    logic [W-1:0]        a_q, b_q, sum_q;
    logic                carry_q;
    logic [CW-1:0]       cnt_q;
`ifdef NSA_OVERFLOW_EN
    logic                ovf_q;
`endif

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [W+NIBBLE_W-1:0] sum_ext;
    logic [W-1:0]        sum_d;
    logic                last_nib;

    // Operands shift right each cycle so the slice always sees bits [3:0];
    // the result shifts in from the top and lands aligned after NIBBLES steps.
    add4_slice u_slice (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        sum_ext  = {nib_sum, sum_q};
        sum_d    = sum_ext[W+NIBBLE_W-1:NIBBLE_W];
        last_nib = (cnt_q == CW'(NIBBLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef NSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= nib_cout;
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_nib) begin
                        state_q <= DONE;
`ifdef NSA_OVERFLOW_EN
                        // carry into the MSB is recovered from the top bit's own sum
                        ovf_q   <= nib_cout ^ (a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
`ifdef NSA_OVERFLOW_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4); overflow checks under NSA_OVERFLOW_EN.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef NSA_OVERFLOW_EN
    logic         out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef NSA_OVERFLOW_EN
       ,.out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check latency and result, then consume it.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input bit scramble);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (scramble) begin
                in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
            end
            tick();
            n++;
        end
        // accepting edge plus four more: DONE visible four edges after acceptance
        chk({tag, "_lat"}, n, 32'd4);
        chk({tag, "_sum"}, {16'd0, out_sum}, {16'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, exp_cout});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int n;
        in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 0;
        rst = 1'b1;
        #3;
        chk("rst_state", {28'd0, in_ready, out_valid, out_cout, |out_sum}, 32'b1000);
        tick();
        rst = 1'b0;

        run_op("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("v8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("vabcd", 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0);
        run_op("scram", 16'h0F0F, 16'h1111, 1'b1, 16'h2021, 1'b0, 1'b1);

        // Backpressure: hold result 3 cycles while new operands are offered.
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 0; in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        in_a = 16'h9999; in_b = 16'h9999; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, out_sum}, 32'h3333);
            chk("hold_rdy", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("hold_rel", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset in the 2nd RUN cycle: nibble 0 already folded into out_sum.
        in_a = 16'h1111; in_b = 16'h2222; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        chk("pre_rst_sum", {16'd0, out_sum}, 32'h3000);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst", {28'd0, in_ready, out_valid, out_cout, |out_sum}, 32'b1000);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) n++;
            tick();
        end
        chk("rst_no_vld", n, 32'd0);
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

`ifdef NSA_OVERFLOW_EN
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0);
        // result consumed; out_ovf still holds the last computed value
        chk("ovf_pos_flag", {31'd0, out_ovf}, 32'd1);
        run_op("ovf_neg", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("ovf_neg_flag", {31'd0, out_ovf}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
